// File: rtl/bpuf_ctrl_pkg.sv
// Shared types, defaults and sizing helpers for the bistable-ring PUF
// evaluation controller.
package bpuf_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXCITE = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } bpuf_state_e;

  localparam int DEF_WIDTH         = 33;
  localparam int DEF_EXCITE_CYCLES = 4;
  localparam int DEF_SETTLE_CYCLES = 16;
  localparam int DEF_NUM_EVALS     = 5;

  function automatic int tally_w(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bpuf_eval_ctrl_tally.sv
// Per-bit response path: 2-flop synchronizer on the asynchronous ring output,
// a tally of sampled ones, and majority/instability of the post-update tally.
module bpuf_bit_tally
  import bpuf_ctrl_pkg::*;
#(
  parameter int NUM_EVALS = DEF_NUM_EVALS
) (
  input  logic clk,
  input  logic rst,
  input  logic i_resp_async,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_maj_next,
  output logic o_unst_next
);

  localparam int TW = tally_w(NUM_EVALS);

  logic          r_sync1;
  logic          r_sync2;
  logic [TW-1:0] r_tally;
  logic [TW-1:0] w_tally_next;

  // synchronizer and tally registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_tally <= '0;
    end else begin
      r_sync1 <= i_resp_async;
      r_sync2 <= r_sync1;
      r_tally <= w_tally_next;
    end
  end

  // next tally; outputs look at it so the result is ready on the DONE entry edge
  always_comb begin
    w_tally_next = r_tally;
    if (i_clr) begin
      w_tally_next = '0;
    end else if (i_inc) begin
      w_tally_next = r_tally + TW'(r_sync2);
    end else begin
      w_tally_next = r_tally;
    end
    o_maj_next  = (w_tally_next > TW'(NUM_EVALS / 2));
    o_unst_next = (w_tally_next != '0) && (w_tally_next != TW'(NUM_EVALS));
  end

endmodule

// File: rtl/bpuf_eval_ctrl.sv
// Evaluation sequencer for the bistable-ring PUF array: excite/release/sample
// repeated NUM_EVALS times, then a majority-voted response with instability flags.
module bpuf_eval_ctrl
  import bpuf_ctrl_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int EXCITE_CYCLES = DEF_EXCITE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int NUM_EVALS     = DEF_NUM_EVALS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] chal_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] resp_out,
  output logic [WIDTH-1:0] unstable,
  output logic [WIDTH-1:0] puf_excite,
  input  logic [WIDTH-1:0] puf_resp
);

  localparam int PH_W = tally_w(max2(EXCITE_CYCLES, SETTLE_CYCLES));
  localparam int EC_W = tally_w(NUM_EVALS);

  bpuf_state_e      r_state;
  bpuf_state_e      w_next;
  logic [PH_W-1:0]  r_phase;
  logic [EC_W-1:0]  r_eval;
  logic [WIDTH-1:0] r_chal;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_resp;
  logic [WIDTH-1:0] r_unst;
  logic [WIDTH-1:0] r_excite;
  logic             w_accept;
  logic             w_inc;
  logic [WIDTH-1:0] w_maj;
  logic [WIDTH-1:0] w_unst;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_inc      = (r_state == S_SAMPLE);
  assign busy       = r_busy;
  assign done       = r_done;
  assign resp_out   = r_resp;
  assign unstable   = r_unst;
  assign puf_excite = r_excite;

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = start ? S_EXCITE : S_IDLE;
      S_EXCITE: w_next = (r_phase == PH_W'(EXCITE_CYCLES - 1)) ? S_SETTLE : S_EXCITE;
      S_SETTLE: w_next = (r_phase == PH_W'(SETTLE_CYCLES - 1)) ? S_SAMPLE : S_SETTLE;
      S_SAMPLE: w_next = (r_eval == EC_W'(NUM_EVALS - 1)) ? S_DONE : S_EXCITE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // state, counters and registered outputs (driven from the next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_phase  <= '0;
      r_eval   <= '0;
      r_chal   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_resp   <= '0;
      r_unst   <= '0;
      r_excite <= '0;
    end else begin
      r_state <= w_next;
      r_phase <= (w_next != r_state) ? '0 : r_phase + PH_W'(1);
      if (w_accept) begin
        r_eval <= '0;
        r_chal <= chal_in;
      end else if (w_inc) begin
        r_eval <= r_eval + EC_W'(1);
      end
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (w_next == S_DONE);
      r_excite <= (w_next == S_EXCITE) ? (w_accept ? chal_in : r_chal) : '0;
      // result holds from DONE until the next acceptance clears it
      if (w_accept) begin
        r_resp <= '0;
        r_unst <= '0;
      end else if (w_next == S_DONE) begin
        r_resp <= w_maj;
        r_unst <= w_unst;
      end
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    bpuf_bit_tally #(.NUM_EVALS(NUM_EVALS)) u_tally (
      .clk          (clk),
      .rst          (rst),
      .i_resp_async (puf_resp[g]),
      .i_clr        (w_accept),
      .i_inc        (w_inc),
      .o_maj_next   (w_maj[g]),
      .o_unst_next  (w_unst[g])
    );
  end

endmodule

// File: tb/tb_bpuf_eval_ctrl.sv
// Scoreboarded bench for bpuf_eval_ctrl: default instance plus a minimal
// single-evaluation instance.
module tb_bpuf_eval_ctrl;

  typedef struct {
    logic [32:0] resp;
    logic [32:0] unst;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, done;
  logic [32:0] chal_in, resp_out, unstable, puf_excite, puf_resp;
  logic        s_start, s_busy, s_done;
  logic [32:0] s_chal, s_resp_out, s_unst, s_excite, s_resp;

  int   n_pass = 0;
  int   n_total = 0;
  exp_t sb[$];

  bpuf_eval_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .chal_in(chal_in), .busy(busy), .done(done),
    .resp_out(resp_out), .unstable(unstable), .puf_excite(puf_excite), .puf_resp(puf_resp)
  );

  bpuf_eval_ctrl #(.WIDTH(33), .EXCITE_CYCLES(1), .SETTLE_CYCLES(3), .NUM_EVALS(1)) dut_small (
    .clk(clk), .rst(rst), .start(s_start), .chal_in(s_chal), .busy(s_busy), .done(s_done),
    .resp_out(s_resp_out), .unstable(s_unst), .puf_excite(s_excite), .puf_resp(s_resp)
  );

  task automatic kick(input logic [32:0] chal);
    start   = 1'b1;
    chal_in = chal;
    @(posedge clk);
    @(negedge clk);
    start   = 1'b0;
    chal_in = ~chal;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; chal_in = '0; puf_resp = '0;
    s_start = 1'b0; s_chal = '0; s_resp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
    n_total++; if (resp_out !== 33'h0) $display("FAIL reset_resp: got %h want 0", resp_out); else n_pass++;
    n_total++; if (unstable !== 33'h0) $display("FAIL reset_unst: got %h want 0", unstable); else n_pass++;
    n_total++; if (puf_excite !== 33'h0) $display("FAIL reset_excite: got %h want 0", puf_excite); else n_pass++;
    n_total++; if (s_busy !== 1'b0) $display("FAIL reset_small_busy: got %b want 0", s_busy); else n_pass++;
  endtask

  // mode 0: plain, 1: bit-0 vote pattern, 2: extra starts at k+10/k+50
  task automatic run_watch(input int mode, input logic [32:0] chal,
                           input logic [32:0] exp_resp, input logic [32:0] exp_unst);
    logic [4:0]  pat;
    logic [32:0] exp_ex;
    pat = 5'b00101;
    sb.push_back('{exp_resp, exp_unst, 106});
    kick(chal);
    for (int c = 1; c <= 112; c++) begin
      if (mode == 1 && ((c - 1) % 21) == 10 && ((c - 1) / 21) < 5)
        puf_resp[0] = pat[(c - 1) / 21];
      if (mode == 2) begin
        start   = (c == 10 || c == 50);
        chal_in = 33'h0_0F0F_0F0F;
      end
      exp_ex = (((c - 1) / 21) < 5 && ((c - 1) % 21) < 4) ? chal : 33'h0;
      n_total++;
      if (puf_excite !== exp_ex) $display("FAIL excite m%0d c=%0d: got %h want %h", mode, c, puf_excite, exp_ex);
      else n_pass++;
      n_total++;
      if (busy !== (c <= 106)) $display("FAIL busy m%0d c=%0d: got %b want %b", mode, c, busy, (c <= 106));
      else n_pass++;
      if (done === 1'b1) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL extra_done m%0d c=%0d: got done want none", mode, c);
        else begin
          exp_t e;
          e = sb.pop_front();
          if (c != e.cyc || resp_out !== e.resp || unstable !== e.unst)
            $display("FAIL result m%0d: got c=%0d resp=%h unst=%h want c=%0d resp=%h unst=%h",
                     mode, c, resp_out, unstable, e.cyc, e.resp, e.unst);
          else n_pass++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    n_total++;
    if (sb.size() != 0) begin
      $display("FAIL missing_done m%0d: got %0d pending want 0", mode, sb.size());
      sb.delete();
    end else n_pass++;
  endtask

  task automatic test_basic();
    puf_resp = 33'h1_5555_5555;
    repeat (3) @(negedge clk);
    run_watch(0, 33'h1_FFFF_FFFF, 33'h1_5555_5555, 33'h0);
  endtask

  task automatic test_vote();
    puf_resp = 33'h0_0000_0001;
    repeat (3) @(negedge clk);
    run_watch(1, 33'h0_0000_0003, 33'h0, 33'h0_0000_0001);
  endtask

  task automatic test_ignore_start();
    puf_resp = 33'h0_ABCD_1234;
    repeat (3) @(negedge clk);
    run_watch(2, 33'h1_2345_6789, 33'h0_ABCD_1234, 33'h0);
  endtask

  task automatic test_mid_reset();
    bit seen;
    seen = 1'b0;
    puf_resp = 33'h1_0000_FFFF;
    repeat (3) @(negedge clk);
    kick(33'h1_FFFF_0000);
    repeat (39) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_total++; if (busy !== 1'b0) $display("FAIL mrst_busy: got %b want 0", busy); else n_pass++;
    n_total++; if (done !== 1'b0) $display("FAIL mrst_done: got %b want 0", done); else n_pass++;
    n_total++; if (resp_out !== 33'h0) $display("FAIL mrst_resp: got %h want 0", resp_out); else n_pass++;
    n_total++; if (unstable !== 33'h0) $display("FAIL mrst_unst: got %h want 0", unstable); else n_pass++;
    n_total++; if (puf_excite !== 33'h0) $display("FAIL mrst_excite: got %h want 0", puf_excite); else n_pass++;
    repeat (80) begin
      @(posedge clk);
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    n_total++; if (seen) $display("FAIL mrst_no_done: got done want none"); else n_pass++;
    run_watch(0, 33'h0_F0F0_F0F0, 33'h1_0000_FFFF, 33'h0);
  endtask

  task automatic test_back_to_back();
    puf_resp = 33'h0_3333_CCCC;
    repeat (3) @(negedge clk);
    for (int m = 1; m <= 3; m++) sb.push_back('{33'h0_3333_CCCC, 33'h0, 107 * m - 1});
    start = 1'b1;
    chal_in = 33'h1_0101_0101;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 321; c++) begin
      if (c == 320) start = 1'b0;
      n_total++;
      if (busy !== ((c % 107) != 0)) $display("FAIL b2b_busy c=%0d: got %b want %b", c, busy, ((c % 107) != 0));
      else n_pass++;
      if (done === 1'b1) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL b2b_extra_done c=%0d: got done want none", c);
        else begin
          exp_t e;
          e = sb.pop_front();
          if (c != e.cyc || resp_out !== e.resp || unstable !== e.unst)
            $display("FAIL b2b_result: got c=%0d resp=%h unst=%h want c=%0d resp=%h unst=%h",
                     c, resp_out, unstable, e.cyc, e.resp, e.unst);
          else n_pass++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    start = 1'b0;
    n_total++;
    if (sb.size() != 0) begin
      $display("FAIL b2b_missing_done: got %0d pending want 0", sb.size());
      sb.delete();
    end else n_pass++;
  endtask

  task automatic test_small();
    s_resp = 33'h1_FFFF_FFFF;
    repeat (3) @(negedge clk);
    sb.push_back('{33'h1_FFFF_FFFF, 33'h0, 6});
    s_start = 1'b1;
    s_chal  = 33'h1_8000_0001;
    @(posedge clk);
    @(negedge clk);
    s_start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      n_total++;
      if (s_excite !== ((c == 1) ? 33'h1_8000_0001 : 33'h0))
        $display("FAIL small_excite c=%0d: got %h", c, s_excite);
      else n_pass++;
      if (s_done === 1'b1) begin
        n_total++;
        if (sb.size() == 0) $display("FAIL small_extra_done c=%0d: got done want none", c);
        else begin
          exp_t e;
          e = sb.pop_front();
          if (c != e.cyc || s_resp_out !== e.resp || s_unst !== e.unst)
            $display("FAIL small_result: got c=%0d resp=%h unst=%h want c=%0d resp=%h unst=%h",
                     c, s_resp_out, s_unst, e.cyc, e.resp, e.unst);
          else n_pass++;
        end
      end
      @(posedge clk);
      @(negedge clk);
    end
    n_total++;
    if (sb.size() != 0) begin
      $display("FAIL small_missing_done: got %0d pending want 0", sb.size());
      sb.delete();
    end else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vote();
    test_ignore_start();
    test_mid_reset();
    test_back_to_back();
    test_small();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
